// File: rtl/pipe_adder_hs.sv
// Purpose : WIDTH-bit adder (a + b + ci) split into STAGES registered carry slices of SW = WIDTH/STAGES bits.
// Latency : STAGES cycles; a beat accepted at edge N is on out_valid/sum/co after edge N+STAGES-1; 1 beat/cycle.
// Backpr. : the whole pipe advances together; it stalls while out_valid & ~out_ready, and in_ready = ~out_valid | out_ready.
//
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready + a, b, ci : operand beat (unsigned operands)
//           out_valid/out_ready + sum, co : result beat, sum = (a+b+ci) mod 2^WIDTH, co = bit WIDTH
//           ovf : signed two's-complement overflow, present only when PIPE_ADDER_OVF_EN is defined
// Macro   : PIPE_ADDER_OVF_EN adds the ovf output and its pipeline register.
module pipe_adder_hs #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW = WIDTH / STAGES;

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipe_adder_hs: WIDTH must be a non-zero multiple of STAGES");
        end
    endgenerate

    // Per-stage pipeline registers. Stage k holds the sum bits of slices 0..k,
    // the carry out of slice k and the operands for the slices still to be added.
    logic [STAGES-1:0]            r_vld;
    logic [STAGES-1:0]            r_cy;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES-1:0][WIDTH-1:0] r_sum;

    // Stage input chains: index 0 is the block input, index k+1 is stage k's register.
    // Building them this way keeps every stage's input selection uniform (also for STAGES=1).
    logic [STAGES:0]              w_cv;
    logic [STAGES:0]              w_cc;
    logic [STAGES:0][WIDTH-1:0]   w_ca;
    logic [STAGES:0][WIDTH-1:0]   w_cb;
    logic [STAGES:0][WIDTH-1:0]   w_cs;

    // Per-stage next values
    logic [STAGES-1:0][SW:0]      w_slc;
    logic [STAGES-1:0][WIDTH-1:0] w_sn;
    logic [STAGES-1:0]            w_cn;

    logic                         w_adv;
    logic                         w_unused_top;

    // Single global advance: every stage moves or every stage holds.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    assign w_cv = {r_vld, in_valid};
    assign w_cc = {r_cy,  ci};
    assign w_ca = {r_a,   a};
    assign w_cb = {r_b,   b};
    assign w_cs = {r_sum, {WIDTH{1'b0}}};

    // The top of each chain is the last stage's own register; only its sum/carry/valid
    // leave the block (directly below), so this entry is not consumed by another stage.
    assign w_unused_top = ^{w_ca[STAGES], w_cb[STAGES], w_cs[STAGES], w_cv[STAGES], w_cc[STAGES]};

    // Slice adders: stage k adds slice k of its delayed operands plus the carry of stage k-1.
    always_comb begin
        w_slc = '0;
        w_sn  = '0;
        w_cn  = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_slc[k] = {1'b0, w_ca[k][k*SW +: SW]}
                     + {1'b0, w_cb[k][k*SW +: SW]}
                     + {{SW{1'b0}}, w_cc[k]};
            w_sn[k]  = w_cs[k];
            w_sn[k][k*SW +: SW] = w_slc[k][SW-1:0];
            w_cn[k]  = w_slc[k][SW];
        end
    end

    // Operands travel whole; each stage reads only the slice it owns, so the
    // slices above k arrive at later stages unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_cy  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
        end else if (w_adv) begin
            r_vld <= w_cv[STAGES-1:0];
            r_cy  <= w_cn;
            r_a   <= w_ca[STAGES-1:0];
            r_b   <= w_cb[STAGES-1:0];
            r_sum <= w_sn;
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign co        = r_cy[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_n;

    // Carry into the MSB is recovered as a^b^sum at the MSB; XOR with the carry out.
    assign w_ovf_n = w_ca[STAGES-1][WIDTH-1] ^ w_cb[STAGES-1][WIDTH-1]
                   ^ w_slc[STAGES-1][SW-1]   ^ w_slc[STAGES-1][SW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_n;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_adder_hs.sv
// Bench for pipe_adder_hs: a 16-bit/4-stage instance checked against a queue model on
// every cycle, an 8-bit/1-stage instance, and (with PIPE_ADDER_OVF_EN) an 8-bit/2-stage
// instance exercising ovf. Directed vectors carry hand-computed expected values.
module tb_pipe_adder_hs;

    logic        clk;
    logic        rst;

    // Main instance: WIDTH=16, STAGES=4
    logic        in_valid, in_ready, out_valid, out_ready, ci, co;
    logic [15:0] a, b, sum;

    // Single-stage instance: WIDTH=8, STAGES=1
    logic        in_valid8, in_ready8, out_valid8, out_ready8, ci8, co8;
    logic [7:0]  a8, b8, sum8;

`ifdef PIPE_ADDER_OVF_EN
    logic        ovf, ovf8;
    logic        in_valid_o, in_ready_o, out_valid_o, out_ready_o, ci_o, co_o, ovf_o;
    logic [7:0]  a_o, b_o, sum_o;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          n_popped = 0;

    // Model: expected {co,sum} of every accepted beat, in acceptance order.
    logic [16:0] q[$];
    logic        hold_pend;
    logic [15:0] hold_sum;
    logic        hold_co;

    logic [15:0] t2_exp [8];
    logic [15:0] t2_got [8];

    pipe_adder_hs #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipe_adder_hs #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ci(ci8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .co(co8)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

`ifdef PIPE_ADDER_OVF_EN
    pipe_adder_hs #(.WIDTH(8), .STAGES(2)) dut_o (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_o), .in_ready(in_ready_o),
        .a(a_o), .b(b_o), .ci(ci_o),
        .out_valid(out_valid_o), .out_ready(out_ready_o),
        .sum(sum_o), .co(co_o), .ovf(ovf_o)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle compare against the queue model (main instance).
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            chk("hs_in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (hold_pend) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {15'd0, co, sum}, {15'd0, hold_co, hold_sum});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("model_result", {15'd0, co, sum}, {15'd0, q.pop_front()});
                    n_popped++;
                end
            end
            if (in_valid && in_ready)
                q.push_back({1'b0, a} + {1'b0, b} + {16'd0, ci});
            hold_pend = out_valid && !out_ready;
            hold_sum  = sum;
            hold_co   = co;
        end
    end

    // Send one beat into an idle main pipe and measure its latency (edges after the accept edge).
    task automatic send_wait(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                             input logic [15:0] es, input logic eco, input string nm);
        int lat;
        lat = -1;
        a = ta; b = tb_v; ci = tci; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            if (out_valid) lat = n;
            else begin @(posedge clk); #1; end
        end
        chk({nm, "_latency"}, lat, 32'd3);
        chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({nm, "_co"}, {31'd0, co}, {31'd0, eco});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got time limit reached expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int first, last, cnt, idx, stall, base;
        logic acc;

        t2_exp = '{16'h0000, 16'h1002, 16'h2002, 16'h3004, 16'h4004, 16'h5006, 16'h6006, 16'h7008};
        hold_pend = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; out_ready8 = 1'b1;
`ifdef PIPE_ADDER_OVF_EN
        in_valid_o = 1'b0; a_o = '0; b_o = '0; ci_o = 1'b0; out_ready_o = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_co", {31'd0, co}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
        @(posedge clk); #1;

        // T1: full carry ripple and overflow boundary
        send_wait(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "t1_ripple_b");
        send_wait(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "t1_ripple_ci");
        send_wait(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "t1_max");

        // T2: 8 back-to-back beats, no gaps
        out_ready = 1'b1;
        a = 16'd0; b = 16'd0; ci = 1'b0; in_valid = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                if (cnt < 8) t2_got[cnt] = sum;
                cnt++;
            end
            if (c < 7) begin
                a = 16'(c + 1); b = 16'((c + 1) * 4096); ci = 1'((c + 1) & 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("t2_first", first, 32'd3);
        chk("t2_last", last, 32'd10);
        chk("t2_count", cnt, 32'd8);
        for (int i = 0; i < 8; i++) chk("t2_sum", {16'd0, t2_got[i]}, {16'd0, t2_exp[i]});

        // T3: backpressure for 5 cycles on a full pipe
        out_ready = 1'b0; idx = 0; stall = 0; base = n_popped;
        a = 16'h0100; b = 16'h0011; ci = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 40 && (n_popped - base) < 6; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                stall++;
                chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
                chk("t3_hold_sum", {16'd0, sum}, 32'h0111);
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 6) begin
                a = 16'((idx + 1) * 256); b = 16'h0011; ci = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (stall >= 5) out_ready = 1'b1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t3_stall_cycles", stall, 32'd5);
        chk("t3_popped", n_popped - base, 32'd6);
        chk("t3_drained", q.size(), 32'd0);

        // T4: reset with 3 beats in flight
        for (int i = 0; i < 3; i++) begin
            a = 16'((i + 1) * 16'h1111); b = 16'h0001; ci = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t4_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_rst_sum", {16'd0, sum}, 32'd0);
        chk("t4_rst_co", {31'd0, co}, 32'd0);
        chk("t4_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t4_no_stale", {31'd0, out_valid}, 32'd0);
        end
        send_wait(16'd3, 16'd4, 1'b0, 16'd7, 1'b0, "t4_new");

        // T5: single-stage 8-bit instance
        a8 = 8'hF0; b8 = 8'h20; ci8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("t5_valid", {31'd0, out_valid8}, 32'd1);
        chk("t5_sum", {24'd0, sum8}, 32'h11);
        chk("t5_co", {31'd0, co8}, 32'd1);
        @(posedge clk); #1;
        chk("t5_drained", {31'd0, out_valid8}, 32'd0);

`ifdef PIPE_ADDER_OVF_EN
        // T6: signed overflow flag
        a_o = 8'h7F; b_o = 8'h01; ci_o = 1'b0; in_valid_o = 1'b1;
        @(posedge clk); #1;
        in_valid_o = 1'b0;
        @(posedge clk); #1;
        chk("t6a_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t6a_sum", {24'd0, sum_o}, 32'h80);
        chk("t6a_co", {31'd0, co_o}, 32'd0);
        chk("t6a_ovf", {31'd0, ovf_o}, 32'd1);
        @(posedge clk); #1;
        a_o = 8'hFF; b_o = 8'h01; ci_o = 1'b0; in_valid_o = 1'b1;
        @(posedge clk); #1;
        in_valid_o = 1'b0;
        @(posedge clk); #1;
        chk("t6b_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t6b_sum", {24'd0, sum_o}, 32'h00);
        chk("t6b_co", {31'd0, co_o}, 32'd1);
        chk("t6b_ovf", {31'd0, ovf_o}, 32'd0);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
